// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and PC alignment constants.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam int unsigned INSTR_BYTES   = 4;

endpackage

// File: rtl/fetch_pc_unit_redirect_select.sv
// Priority mux over the three redirect sources (jr > jump > branch); word-aligns the target.
module redirect_select
    import mips_pkg::*;
(
    input  logic        jr_en,
    input  logic [31:0] jr_addr,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        branch_en,
    input  logic [31:0] branch_addr,
    output logic        redirect,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] sel_addr;

    always_comb begin
        sel_addr = 32'h0;
        if (jr_en) begin
            sel_addr = jr_addr;
        end else if (jump_en) begin
            sel_addr = jump_addr;
        end else if (branch_en) begin
            sel_addr = branch_addr;
        end
    end

    assign redirect   = jr_en | jump_en | branch_en;
    assign target     = sel_addr & PC_ALIGN_MASK;
    assign misaligned = redirect & (sel_addr[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch FSM: requests a word, holds it until
// downstream accepts it, and applies jr/jump/branch redirects at any time.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = INSTR_BYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic         instr_valid,
    input  logic         instr_accept,
    output logic [3:0]   pc_upper4,
    input  logic         jump_en,
    input  logic [31:0]  jump_addr,
    input  logic         branch_en,
    input  logic [31:0]  branch_addr,
    input  logic         jr_en,
    input  logic [31:0]  jr_addr,
    output logic         misalign_err,
    output fetch_state_t dbg_state
);

    // Handshakes: imem_rdata is taken only in a cycle where imem_req and
    // imem_ready are both 1; the held instruction is consumed in a cycle
    // where instr_valid and instr_accept are both 1.

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic         instr_valid_q;
    logic         misalign_q;

    logic         redirect;
    logic [31:0]  target;
    logic         misaligned;

    redirect_select u_redirect_select (
        .jr_en       (jr_en),
        .jr_addr     (jr_addr),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .redirect    (redirect),
        .target      (target),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= misaligned;
            case (state_q)
                BOOT: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    state_q <= FETCH;
                end
                FETCH: begin
                    // A redirect wins over a returning word: the word belongs to the stale path.
                    if (redirect) begin
                        pc_q <= target;
                    end else if (imem_ready) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        pc_q          <= pc_q + 32'(PC_STEP);
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= target;
                        state_q       <= FETCH;
                    end else if (instr_accept) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= FETCH;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_valid  = instr_valid_q;
    assign misalign_err = misalign_q;
    assign dbg_state    = state_q;
    assign pc_upper4    = 4'((instr_pc_q + 32'(PC_STEP)) >> 28);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: boot, backpressure, redirects, priority, wrap, async reset.
module tb_fetch_pc_unit;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic         clk;
    logic         rst_n;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready;
    logic [31:0]  imem_rdata;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic         instr_valid;
    logic         instr_accept;
    logic [3:0]   pc_upper4;
    logic         jump_en;
    logic [31:0]  jump_addr;
    logic         branch_en;
    logic [31:0]  branch_addr;
    logic         jr_en;
    logic [31:0]  jr_addr;
    logic         misalign_err;
    fetch_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_accept (instr_accept),
        .pc_upper4    (pc_upper4),
        .jump_en      (jump_en),
        .jump_addr    (jump_addr),
        .branch_en    (branch_en),
        .branch_addr  (branch_addr),
        .jr_en        (jr_en),
        .jr_addr      (jr_addr),
        .misalign_err (misalign_err),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0;
        instr_accept = 1'b0;
        jump_en      = 1'b0;
        jump_addr    = 32'h0;
        branch_en    = 1'b0;
        branch_addr  = 32'h0;
        jr_en        = 1'b0;
        jr_addr      = 32'h0;

        // Reset and boot
        step(); step(); step();
        check("rst_req",      32'(imem_req), 32'h0);
        check("rst_valid",    32'(instr_valid), 32'h0);
        check("rst_instr",    instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);
        check("rst_pc",       imem_addr, 32'h0040_0000);
        check("rst_state",    32'(dbg_state), 32'(BOOT));
        rst_n = 1'b1;
        #3;
        check("boot_req", 32'(imem_req), 32'h0);
        step();
        check("fetch0_req",  32'(imem_req), 32'h1);
        check("fetch0_addr", imem_addr, 32'h0040_0000);

        // Sequential fetch with backpressure
        imem_ready = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        imem_ready = 1'b0;
        check("f0_valid",    32'(instr_valid), 32'h1);
        check("f0_instr",    instr, 32'h2008_0005);
        check("f0_instr_pc", instr_pc, 32'h0040_0000);
        check("f0_req_hold", 32'(imem_req), 32'h0);
        check("f0_upper4",   32'(pc_upper4), 32'h0);
        step(); step();
        check("bp_valid",    32'(instr_valid), 32'h1);
        check("bp_instr_pc", instr_pc, 32'h0040_0000);
        check("bp_instr",    instr, 32'h2008_0005);
        instr_accept = 1'b1;
        step();
        instr_accept = 1'b0;
        check("acc_valid", 32'(instr_valid), 32'h0);
        check("acc_req",   32'(imem_req), 32'h1);
        check("acc_addr",  imem_addr, 32'h0040_0004);
        imem_ready = 1'b1;
        imem_rdata = 32'h2009_0007;
        step();
        imem_ready = 1'b0;
        check("f1_instr",    instr, 32'h2009_0007);
        check("f1_instr_pc", instr_pc, 32'h0040_0004);

        // Jump during HOLD flushes the held word
        jump_en   = 1'b1;
        jump_addr = 32'hF000_0100;
        step();
        jump_en = 1'b0;
        check("jmp_valid",    32'(instr_valid), 32'h0);
        check("jmp_addr",     imem_addr, 32'hF000_0100);
        check("jmp_req",      32'(imem_req), 32'h1);
        check("jmp_misalign", 32'(misalign_err), 32'h0);
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0000;
        step();
        imem_ready = 1'b0;
        check("jmp_instr_pc", instr_pc, 32'hF000_0100);
        check("jmp_upper4",   32'(pc_upper4), 32'hF);
        instr_accept = 1'b1;
        step();
        instr_accept = 1'b0;
        check("jmp_next_addr", imem_addr, 32'hF000_0104);

        // Branch coinciding with imem_ready drops the word
        branch_en   = 1'b1;
        branch_addr = 32'h0040_0020;
        imem_ready  = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        branch_en  = 1'b0;
        imem_ready = 1'b0;
        check("br_valid", 32'(instr_valid), 32'h0);
        check("br_addr",  imem_addr, 32'h0040_0020);
        check("br_state", 32'(dbg_state), 32'(FETCH));
        check("br_instr", instr, 32'hF000_0000 & 32'h0);

        // jr beats jump; misaligned target pulses misalign_err once
        jr_en     = 1'b1;
        jr_addr   = 32'h0000_1003;
        jump_en   = 1'b1;
        jump_addr = 32'h0000_2000;
        step();
        jr_en   = 1'b0;
        jump_en = 1'b0;
        check("pri_addr",      imem_addr, 32'h0000_1000);
        check("pri_misalign1", 32'(misalign_err), 32'h1);
        step();
        check("pri_misalign0", 32'(misalign_err), 32'h0);
        check("pri_addr_hold", imem_addr, 32'h0000_1000);

        // PC wraps modulo 2^32
        jump_en   = 1'b1;
        jump_addr = 32'hFFFF_FFFC;
        step();
        jump_en = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ready = 1'b0;
        check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_upper4",   32'(pc_upper4), 32'h0);
        instr_accept = 1'b1;
        step();
        instr_accept = 1'b0;
        check("wrap_next_addr", imem_addr, 32'h0000_0000);
        check("wrap_misalign",  32'(misalign_err), 32'h0);

        // Asynchronous reset between clock edges, mid-FETCH
        imem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",   32'(imem_req), 32'h0);
        check("arst_valid", 32'(instr_valid), 32'h0);
        check("arst_pc",    imem_addr, RST_PC);
        check("arst_state", 32'(dbg_state), 32'(BOOT));
        step();
        check("arst_instr", instr, 32'h0);
        imem_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
